counter_checker: RTL and testbench
==================================

Name: counter_checker

Overview:
- Consumer-side monitor for the free-running WIDTH-bit up-counter stream (default 4 bits), i.e. the reader for the counter writer.
- Samples the count each valid cycle and locks onto the +1-per-sample sequence, with 2^WIDTH-1 -> 0 wrap allowed.
- After lock, flags every broken step and keeps a saturating error tally.
- Sits beside the counter in self-checking benches and in the top-level health logic.

Parameters:
- WIDTH, 4, bit width of the monitored count.
- LOCK_COUNT, 2, consecutive correct steps needed to go ACQUIRE -> LOCKED (legal range 1..15).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST_X  input  1  reset, synchronous, active-low.
- i_valid  input  1  i_cnt is sampled this cycle when high.
- i_cnt  input  WIDTH  monitored counter value.
- i_clear  input  1  synchronous clear of o_err_cnt.
- o_locked  output  1  high while state == LOCKED.
- o_err  output  1  one-cycle pulse, cycle after a mismatching sample taken in LOCKED.
- o_err_cnt  output  ERR_CNT_W  saturating count of errors.
- o_expected  output  WIDTH  next expected value (last+1 mod 2^WIDTH); 0 in UNSYNC.
- o_state  output  2  UNSYNC=0, ACQUIRE=1, LOCKED=2.

Behaviour:
- Reset (RST_X==0 at posedge):
  - state=UNSYNC; last=0; good_run=0.
  - All outputs 0.
  - Reset overrides every other input, including reset mid-lock or mid-error.
- Internal regs:
  - last: WIDTH bits, last accepted sample.
  - good_run: 4 bits.
  - Match condition: i_cnt == (last+1) truncated to WIDTH. Wrap 15->0 (WIDTH=4) is a match.
- i_valid==0: state, last, good_run and o_err_cnt hold; o_err=0. i_clear is still honoured.
- UNSYNC, valid: last<=i_cnt; good_run<=0; -> ACQUIRE. No error is possible.
- ACQUIRE, valid, match:
  - last<=i_cnt.
  - If good_run+1 == LOCK_COUNT: -> LOCKED, good_run<=0.
  - Else: good_run<=good_run+1.
- ACQUIRE, valid, mismatch: last<=i_cnt; good_run<=0; stay in ACQUIRE; no o_err, no increment.
- LOCKED, valid, match: last<=i_cnt; stay in LOCKED.
- LOCKED, valid, mismatch:
  - last<=i_cnt; good_run<=0; -> ACQUIRE.
  - o_err<=1 for exactly one cycle.
  - o_err_cnt<=o_err_cnt+1, saturating at 2^ERR_CNT_W-1 (no wrap).
- Latency:
  - All outputs are registered and reflect the sample from the previous posedge.
  - o_locked rises the cycle after the LOCK_COUNT-th consecutive match.
  - o_err rises the cycle after the bad sample.
- Repeated value (stall, e.g. 5,5) counts as a mismatch. Skipped value (5,7) counts as a mismatch.
- i_clear: o_err_cnt<=0. If an error occurs in the same cycle:
  - Clear wins (o_err_cnt=0).
  - o_err still pulses.
  - State transition still happens.
- o_expected = (last+1) mod 2^WIDTH when state != UNSYNC, else 0.
- o_state encoding 3 is unreachable; if entered, -> UNSYNC on the next posedge.

Test Plan:
1. Reset and lock: hold RST_X=0 for 2 cycles, then counter stream 0,1,2,3 with valid=1.
   - Response: o_state 0->1 after sample 0.
   - o_locked=1 the cycle after sample 2 (two matches).
   - o_expected=4 after sample 3.
   - o_err never asserted.
2. Wrap: locked stream 13,14,15,0,1.
   - Response: o_locked stays 1, o_err stays 0.
   - o_expected=0 after sample 15.
3. Error and relock: locked at 6, then inject 9, then 10,11.
   - Response: o_err=1 for one cycle after 9; o_err_cnt=1; o_state=1.
   - o_locked=1 again after sample 11.
4. Valid gaps: locked stream 3, valid=0 for 3 cycles with i_cnt=garbage, then 4.
   - Response: no error; o_locked stays 1; o_expected holds at 4 during the gap.
5. Saturation and clear: ERR_CNT_W=2, force 5 locked-state errors (relock between each).
   - Response: o_err_cnt reads 1,2,3,3,3.
   - i_clear coincident with the 6th error: o_err=1 and o_err_cnt=0.
6. Synchronous reset mid-lock: drop RST_X for 1 cycle while locked at 8.
   - Response: next posedge gives o_state=0, o_locked=0, o_err_cnt=0, o_expected=0.
   - Deasserting reset asynchronously between edges has no effect until the next posedge.

Source files
------------

// File: rtl/counter_checker.sv
// Consumer-side monitor for a free-running up-counter stream: locks onto the
// +1-per-sample sequence (with wrap), then flags and tallies every broken step.
module counter_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  input  logic                 i_valid,
  input  logic [WIDTH-1:0]     i_cnt,
  input  logic                 i_clear,
  output logic                 o_locked,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
  output logic [WIDTH-1:0]     o_expected,
  output logic [1:0]           o_state
);

  // Handshake: i_valid alone qualifies i_cnt on each posedge; there is no
  // ready, the monitor accepts every valid sample unconditionally.

  typedef enum logic [1:0] {
    ST_UNSYNC  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_last;
  logic [3:0]           r_good_run;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 r_locked;
  logic [WIDTH-1:0]     r_expected;

  logic [WIDTH-1:0]     w_last_inc;
  logic [WIDTH-1:0]     w_in_inc;
  logic [3:0]           w_run_inc;
  logic                 w_match;
  logic                 w_lock_hit;
  logic                 w_err_sat;

  always_comb begin
    w_last_inc = r_last + WIDTH'(1);
    w_in_inc   = i_cnt + WIDTH'(1);
    w_match    = (i_cnt == w_last_inc);
    w_run_inc  = r_good_run + 4'd1;
    w_lock_hit = (w_run_inc == 4'(LOCK_COUNT));
    w_err_sat  = &r_err_cnt;
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      r_state    <= ST_UNSYNC;
      r_last     <= '0;
      r_good_run <= '0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
      r_locked   <= 1'b0;
      r_expected <= '0;
    end else begin
      r_err <= 1'b0;
      if (i_clear) begin
        r_err_cnt <= '0;
      end
      case (r_state)
        ST_UNSYNC: begin
          if (i_valid) begin
            r_last     <= i_cnt;
            r_good_run <= '0;
            r_expected <= w_in_inc;
            r_state    <= ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (i_valid) begin
            r_last     <= i_cnt;
            r_expected <= w_in_inc;
            if (w_match) begin
              if (w_lock_hit) begin
                r_state    <= ST_LOCKED;
                r_locked   <= 1'b1;
                r_good_run <= '0;
              end else begin
                r_good_run <= w_run_inc;
              end
            end else begin
              r_good_run <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (i_valid) begin
            r_last     <= i_cnt;
            r_expected <= w_in_inc;
            if (!w_match) begin
              r_state    <= ST_ACQUIRE;
              r_locked   <= 1'b0;
              r_good_run <= '0;
              r_err      <= 1'b1;
              // A coincident clear must leave the tally at zero.
              if (!i_clear && !w_err_sat) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
              end
            end
          end
        end
        default: begin
          r_state    <= ST_UNSYNC;
          r_locked   <= 1'b0;
          r_good_run <= '0;
          r_expected <= '0;
        end
      endcase
    end
  end

  assign o_locked   = r_locked;
  assign o_err      = r_err;
  assign o_err_cnt  = r_err_cnt;
  assign o_expected = r_expected;
  assign o_state    = r_state;

endmodule

// File: tb/tb_counter_checker.sv
// Self-checking bench for counter_checker: directed scenarios plus a random
// stream compared against a sample-level reference model.
module tb_counter_checker;

  localparam int W    = 4;
  localparam int LOCK = 2;
  localparam int CW   = 2;
  localparam int MODN = 1 << W;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_x;
  logic          i_valid;
  logic [W-1:0]  i_cnt;
  logic          i_clear;
  logic          o_locked;
  logic          o_err;
  logic [CW-1:0] o_err_cnt;
  logic [W-1:0]  o_expected;
  logic [1:0]    o_state;

  int n_tests;
  int n_fail;

  // reference model: mode 0 unsynced, 1 acquiring, 2 locked
  int m_mode;
  int m_last;
  int m_run;
  int m_err;
  int m_cnt;

  logic [CW-1:0] exp_q[$];

  counter_checker #(.WIDTH(W), .LOCK_COUNT(LOCK), .ERR_CNT_W(CW)) dut (
    .CLK       (clk),
    .RST_X     (rst_x),
    .i_valid   (i_valid),
    .i_cnt     (i_cnt),
    .i_clear   (i_clear),
    .o_locked  (o_locked),
    .o_err     (o_err),
    .o_err_cnt (o_err_cnt),
    .o_expected(o_expected),
    .o_state   (o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_last = 0; m_run = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_update(input logic v, input logic [W-1:0] c, input logic clr);
    int ci;
    bit match;
    ci = int'(c);
    m_err = 0;
    if (clr) m_cnt = 0;
    if (v) begin
      match = (ci == (m_last + 1) % MODN);
      if (m_mode == 0) begin
        m_mode = 1; m_run = 0;
      end else if (m_mode == 1) begin
        if (match) begin
          m_run = m_run + 1;
          if (m_run >= LOCK) begin m_mode = 2; m_run = 0; end
        end else begin
          m_run = 0;
        end
      end else if (!match) begin
        m_mode = 1; m_run = 0; m_err = 1;
        if (!clr) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      end
      m_last = ci;
    end
  endtask

  function automatic logic [W-1:0] model_expected();
    return (m_mode == 0) ? W'(0) : W'((m_last + 1) % MODN);
  endfunction

  // driver tasks: inputs change #1 after an edge, outputs sampled #1 after the next
  task automatic apply_reset(input int ncyc);
    rst_x = 1'b0; i_valid = 1'b0; i_cnt = '0; i_clear = 1'b0;
    repeat (ncyc) @(posedge clk);
    model_reset();
    #1;
    rst_x = 1'b1;
  endtask

  task automatic step(input logic v, input logic [W-1:0] c, input logic clr);
    i_valid = v; i_cnt = c; i_clear = clr;
    @(posedge clk);
    model_update(v, c, clr);
    #1;
  endtask

  task automatic test_reset_and_lock();
    apply_reset(2);
    n_tests++; if (o_state !== 2'd0 || o_locked !== 1'b0 || o_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl state=%0d locked=%0b err=%0b want 0/0/0", o_state, o_locked, o_err);
    end
    n_tests++; if (o_err_cnt !== '0 || o_expected !== '0) begin
      n_fail++; $display("FAIL reset_data err_cnt=%0d expected=%0d want 0/0", o_err_cnt, o_expected);
    end
    step(1'b1, 4'd0, 1'b0);
    n_tests++; if (o_state !== 2'd1) begin
      n_fail++; $display("FAIL lock_first_state got=%0d want=1", o_state);
    end
    step(1'b1, 4'd1, 1'b0);
    n_tests++; if (o_locked !== 1'b0) begin
      n_fail++; $display("FAIL lock_early got=%0b want=0", o_locked);
    end
    step(1'b1, 4'd2, 1'b0);
    n_tests++; if (o_locked !== 1'b1 || o_state !== 2'd2) begin
      n_fail++; $display("FAIL lock_rise locked=%0b state=%0d want 1/2", o_locked, o_state);
    end
    step(1'b1, 4'd3, 1'b0);
    n_tests++; if (o_expected !== 4'd4 || o_err !== 1'b0) begin
      n_fail++; $display("FAIL lock_expected expected=%0d err=%0b want 4/0", o_expected, o_err);
    end
  endtask

  task automatic test_wrap();
    for (int v = 4; v <= 17; v++) begin
      step(1'b1, W'(v % MODN), 1'b0);
      n_tests++; if (o_locked !== 1'b1 || o_err !== 1'b0) begin
        n_fail++; $display("FAIL wrap_locked sample=%0d locked=%0b err=%0b want 1/0", v % MODN, o_locked, o_err);
      end
      if (v == 15) begin
        n_tests++; if (o_expected !== 4'd0) begin
          n_fail++; $display("FAIL wrap_expected got=%0d want=0", o_expected);
        end
      end
    end
  endtask

  task automatic test_error_relock();
    for (int v = 2; v <= 6; v++) step(1'b1, W'(v), 1'b0);
    step(1'b1, 4'd9, 1'b0);
    n_tests++; if (o_err !== 1'b1 || o_err_cnt !== 2'd1 || o_state !== 2'd1) begin
      n_fail++; $display("FAIL err_pulse err=%0b cnt=%0d state=%0d want 1/1/1", o_err, o_err_cnt, o_state);
    end
    step(1'b1, 4'd10, 1'b0);
    n_tests++; if (o_err !== 1'b0 || o_locked !== 1'b0) begin
      n_fail++; $display("FAIL err_one_cycle err=%0b locked=%0b want 0/0", o_err, o_locked);
    end
    step(1'b1, 4'd11, 1'b0);
    n_tests++; if (o_locked !== 1'b1 || o_err_cnt !== 2'd1) begin
      n_fail++; $display("FAIL relock locked=%0b cnt=%0d want 1/1", o_locked, o_err_cnt);
    end
  endtask

  task automatic test_valid_gaps();
    for (int v = 12; v <= 19; v++) step(1'b1, W'(v % MODN), 1'b0);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, W'($urandom_range(0, MODN - 1)), 1'b0);
      n_tests++; if (o_err !== 1'b0 || o_locked !== 1'b1 || o_expected !== 4'd4) begin
        n_fail++; $display("FAIL gap_hold err=%0b locked=%0b expected=%0d want 0/1/4", o_err, o_locked, o_expected);
      end
    end
    step(1'b1, 4'd4, 1'b0);
    n_tests++; if (o_err !== 1'b0 || o_locked !== 1'b1 || o_expected !== 4'd5) begin
      n_fail++; $display("FAIL gap_resume err=%0b locked=%0b expected=%0d want 0/1/5", o_err, o_locked, o_expected);
    end
  endtask

  task automatic test_saturate_clear();
    int sat_exp[5];
    logic [W-1:0] bad;
    sat_exp = '{1, 2, 3, 3, 3};
    step(1'b1, 4'd5, 1'b1);
    n_tests++; if (o_err_cnt !== 2'd0 || o_locked !== 1'b1) begin
      n_fail++; $display("FAIL clear cnt=%0d locked=%0b want 0/1", o_err_cnt, o_locked);
    end
    for (int k = 0; k < 5; k++) begin
      bad = W'(m_last + 3);
      step(1'b1, bad, 1'b0);
      n_tests++; if (o_err !== 1'b1 || o_err_cnt !== CW'(sat_exp[k])) begin
        n_fail++; $display("FAIL sat_%0d err=%0b cnt=%0d want 1/%0d", k, o_err, o_err_cnt, sat_exp[k]);
      end
      step(1'b1, bad + W'(1), 1'b0);
      step(1'b1, bad + W'(2), 1'b0);
    end
    bad = W'(m_last + 5);
    step(1'b1, bad, 1'b1);
    n_tests++; if (o_err !== 1'b1 || o_err_cnt !== 2'd0 || o_state !== 2'd1) begin
      n_fail++; $display("FAIL clear_vs_err err=%0b cnt=%0d state=%0d want 1/0/1", o_err, o_err_cnt, o_state);
    end
  endtask

  task automatic test_reset_mid_lock();
    int seq[11];
    seq = '{6, 7, 8, 1, 2, 3, 4, 5, 6, 7, 8};
    for (int k = 0; k < 11; k++) step(1'b1, W'(seq[k]), 1'b0);
    n_tests++; if (o_locked !== 1'b1 || o_err_cnt !== 2'd1 || o_expected !== 4'd9) begin
      n_fail++; $display("FAIL pre_reset locked=%0b cnt=%0d expected=%0d want 1/1/9", o_locked, o_err_cnt, o_expected);
    end
    rst_x = 1'b0; i_valid = 1'b1; i_cnt = 4'd9; i_clear = 1'b0;
    #3;
    n_tests++; if (o_locked !== 1'b1 || o_state !== 2'd2) begin
      n_fail++; $display("FAIL reset_is_sync locked=%0b state=%0d want 1/2", o_locked, o_state);
    end
    @(posedge clk);
    model_reset();
    #1;
    n_tests++; if (o_state !== 2'd0 || o_locked !== 1'b0 || o_err_cnt !== '0 || o_expected !== '0) begin
      n_fail++; $display("FAIL reset_mid state=%0d locked=%0b cnt=%0d expected=%0d want 0/0/0/0", o_state, o_locked, o_err_cnt, o_expected);
    end
    #2;
    rst_x = 1'b1; i_cnt = 4'd10;
    #1;
    n_tests++; if (o_state !== 2'd0) begin
      n_fail++; $display("FAIL deassert_between_edges state=%0d want 0", o_state);
    end
    @(posedge clk);
    model_update(1'b1, 4'd10, 1'b0);
    #1;
    n_tests++; if (o_state !== 2'd1 || o_expected !== 4'd11) begin
      n_fail++; $display("FAIL post_reset state=%0d expected=%0d want 1/11", o_state, o_expected);
    end
  endtask

  task automatic test_random_stream();
    logic          v;
    logic          clr;
    logic [W-1:0]  c;
    logic [CW-1:0] e_cnt;
    apply_reset(1);
    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) < 85) c = W'((m_last + 1) % MODN);
      else                            c = W'($urandom_range(0, MODN - 1));
      step(v, c, clr);
      exp_q.push_back(CW'(m_cnt));
      e_cnt = exp_q.pop_front();
      n_tests++; if (o_state !== 2'(m_mode)) begin
        n_fail++; $display("FAIL rnd_state cyc=%0d got=%0d want=%0d", n, o_state, m_mode);
      end
      n_tests++; if (o_locked !== (m_mode == 2)) begin
        n_fail++; $display("FAIL rnd_locked cyc=%0d got=%0b want=%0b", n, o_locked, m_mode == 2);
      end
      n_tests++; if (o_err !== 1'(m_err)) begin
        n_fail++; $display("FAIL rnd_err cyc=%0d got=%0b want=%0d", n, o_err, m_err);
      end
      n_tests++; if (o_err_cnt !== e_cnt) begin
        n_fail++; $display("FAIL rnd_err_cnt cyc=%0d got=%0d want=%0d", n, o_err_cnt, e_cnt);
      end
      n_tests++; if (o_expected !== model_expected()) begin
        n_fail++; $display("FAIL rnd_expected cyc=%0d got=%0d want=%0d", n, o_expected, model_expected());
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_x = 1'b0; i_valid = 1'b0; i_cnt = '0; i_clear = 1'b0;
    model_reset();
    #1;
    test_reset_and_lock();
    test_wrap();
    test_error_relock();
    test_valid_gaps();
    test_saturate_clear();
    test_reset_mid_lock();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
